// File: rtl/piano_pkg.sv
// Shared constants, frame FSM states and the scancode-to-note map for the PS/2 note decoder.
// The PS2_SHARPS_EN macro adds the sharp keys (W E T Y U) to the map.
package piano_pkg;

    localparam int unsigned NOTE_W    = 8;
    localparam logic [7:0]  NOTE_STOP = 8'd99;

    localparam logic [7:0]  SC_BREAK  = 8'hF0;
    localparam logic [7:0]  SC_EXT    = 8'hE0;

    localparam logic [7:0]  SC_KEY_A  = 8'h1C;
    localparam logic [7:0]  SC_KEY_S  = 8'h1B;
    localparam logic [7:0]  SC_KEY_D  = 8'h23;
    localparam logic [7:0]  SC_KEY_F  = 8'h2B;
    localparam logic [7:0]  SC_KEY_G  = 8'h34;
    localparam logic [7:0]  SC_KEY_H  = 8'h33;
    localparam logic [7:0]  SC_KEY_J  = 8'h3B;
    localparam logic [7:0]  SC_KEY_K  = 8'h42;
`ifdef PS2_SHARPS_EN
    localparam logic [7:0]  SC_KEY_W  = 8'h1D;
    localparam logic [7:0]  SC_KEY_E  = 8'h24;
    localparam logic [7:0]  SC_KEY_T  = 8'h2C;
    localparam logic [7:0]  SC_KEY_Y  = 8'h35;
    localparam logic [7:0]  SC_KEY_U  = 8'h3C;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_e;

    typedef struct packed {
        logic             hit;
        logic [NOTE_W-1:0] note;
    } note_map_t;

    // Map a make code to its note index; hit=0 for unmapped codes.
    function automatic note_map_t map_scancode(input logic [7:0] sc);
        note_map_t m;
        m.hit  = 1'b1;
        m.note = '0;
        case (sc)
            SC_KEY_A: m.note = 8'd0;
            SC_KEY_S: m.note = 8'd1;
            SC_KEY_D: m.note = 8'd2;
            SC_KEY_F: m.note = 8'd3;
            SC_KEY_G: m.note = 8'd4;
            SC_KEY_H: m.note = 8'd5;
            SC_KEY_J: m.note = 8'd6;
            SC_KEY_K: m.note = 8'd7;
`ifdef PS2_SHARPS_EN
            SC_KEY_W: m.note = 8'd8;
            SC_KEY_E: m.note = 8'd9;
            SC_KEY_T: m.note = 8'd10;
            SC_KEY_Y: m.note = 8'd11;
            SC_KEY_U: m.note = 8'd12;
`endif
            default:  m.hit  = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronisers, falling-edge detect, 11-bit frame FSM with odd
// parity and stop checks, and an inactivity timeout that aborts partial frames.
module ps2_rx_frame
    import piano_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       byte_stb_o,
    output logic       frame_err_o
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic                   fall;
    logic                   dat;

    frame_state_e state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   shreg_q, shreg_d;
    logic         par_ok_q, par_ok_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic         stb_q, stb_d;
    logic         err_q, err_d;

    // Synchronise both PS/2 lines (idle high) and keep the previous clock level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign dat  = dat_sync_q[SYNC_STAGES-1];

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_ok_q  <= 1'b0;
            tmo_q     <= '0;
            stb_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_ok_q  <= par_ok_d;
            tmo_q     <= tmo_d;
            stb_q     <= stb_d;
            err_q     <= err_d;
        end
    end

    // Next state: a falling edge advances the frame and reloads the timeout; otherwise count.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_ok_d  = par_ok_q;
        tmo_d     = tmo_q;
        stb_d     = 1'b0;
        err_d     = 1'b0;
        if (fall) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!dat) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shreg_d = {dat, shreg_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    par_ok_d = ^{shreg_q, dat};
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    if (par_ok_q && dat) begin
                        stb_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    assign byte_o      = shreg_q;
    assign byte_stb_o  = stb_q;
    assign frame_err_o = err_q;

endmodule

// File: rtl/ps2_note_decoder.sv
// PS/2 keyboard to held-note decoder: make/break/extend handling over received bytes.
// Build option PS2_SHARPS_EN enables the sharp keys in the map.
module ps2_note_decoder
    import piano_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  STOP_CODE      = NOTE_STOP
) (
    input  logic       iClk,
    input  logic       iReset_n,
    input  logic       iPs2_Clk,
    input  logic       iPs2_Dat,
    output logic [7:0] oNote_Code,
    output logic       oNote_Valid,
    output logic       oFrame_Err
);

    logic [7:0] rx_byte;
    logic       rx_stb;
    logic       rx_err;
    note_map_t  map;

    logic [7:0] note_q, note_d;
    logic       valid_q, valid_d;
    logic       err_q;
    logic       brk_q, brk_d;
    logic       ext_q, ext_d;

    ps2_rx_frame #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (iClk),
        .rst_n       (iReset_n),
        .ps2_clk_i   (iPs2_Clk),
        .ps2_dat_i   (iPs2_Dat),
        .byte_o      (rx_byte),
        .byte_stb_o  (rx_stb),
        .frame_err_o (rx_err)
    );

    assign map = map_scancode(rx_byte);

    // Output and prefix-flag registers.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            note_q  <= STOP_CODE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
        end else begin
            note_q  <= note_d;
            valid_q <= valid_d;
            err_q   <= rx_err;
            brk_q   <= brk_d;
            ext_q   <= ext_d;
        end
    end

    // Byte interpretation: prefixes set flags, extended codes are dropped, last press wins.
    always_comb begin
        note_d  = note_q;
        valid_d = 1'b0;
        brk_d   = brk_q;
        ext_d   = ext_q;
        if (rx_err) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (rx_stb) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BREAK) begin
                brk_d = 1'b1;
            end else if (ext_q) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end else if (brk_q) begin
                brk_d = 1'b0;
                if (map.hit && (map.note == note_q)) begin
                    note_d  = STOP_CODE;
                    valid_d = 1'b1;
                end
            end else if (map.hit && (map.note != note_q)) begin
                note_d  = map.note;
                valid_d = 1'b1;
            end
        end
    end

    assign oNote_Code  = note_q;
    assign oNote_Valid = valid_q;
    assign oFrame_Err  = err_q;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Directed bench for ps2_note_decoder: expected note changes are queued as frames are sent,
// observed oNote_Valid pulses are collected, and both are compared at each checkpoint.
module tb_ps2_note_decoder;

    localparam int unsigned TMO  = 200;
    localparam int unsigned HALF = 8;

    logic       iClk;
    logic       iReset_n;
    logic       iPs2_Clk;
    logic       iPs2_Dat;
    logic [7:0] oNote_Code;
    logic       oNote_Valid;
    logic       oFrame_Err;

    int         checks;
    int         errors;
    int         err_seen;
    int         exp_err;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    ps2_note_decoder #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TMO),
        .STOP_CODE      (8'd99)
    ) dut (
        .iClk        (iClk),
        .iReset_n    (iReset_n),
        .iPs2_Clk    (iPs2_Clk),
        .iPs2_Dat    (iPs2_Dat),
        .oNote_Code  (oNote_Code),
        .oNote_Valid (oNote_Valid),
        .oFrame_Err  (oFrame_Err)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Collect output events away from the active edge.
    always @(negedge iClk) begin
        if (oNote_Valid) obs_q.push_back(oNote_Code);
        if (oFrame_Err)  err_seen = err_seen + 1;
    end

    task automatic ps2_bit(input logic b);
        @(negedge iClk);
        iPs2_Dat = b;
        repeat (HALF) @(negedge iClk);
        iPs2_Clk = 1'b0;
        repeat (HALF) @(negedge iClk);
        iPs2_Clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop_b);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ flip_par);
        ps2_bit(stop_b);
        iPs2_Dat = 1'b1;
        repeat (40) @(negedge iClk);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks = checks + 1;
        assert (obs === exp)
        else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare queued note changes against observed pulses, then the held code and error count.
    task automatic checkpoint(input string tag, input int exp_code);
        check({tag, "_pulses"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_note"}, int'(obs_q.pop_front()), int'(exp_q.pop_front()));
        end
        obs_q.delete();
        exp_q.delete();
        check({tag, "_code"}, int'(oNote_Code), exp_code);
        check({tag, "_errs"}, err_seen, exp_err);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        err_seen = 0;
        exp_err  = 0;
        iPs2_Clk = 1'b1;
        iPs2_Dat = 1'b1;
        iReset_n = 1'b0;
        repeat (5) @(negedge iClk);
        iReset_n = 1'b1;
        repeat (5) @(negedge iClk);

        // Reset state
        check("rst_code",  int'(oNote_Code),  99);
        check("rst_valid", int'(oNote_Valid), 0);
        check("rst_err",   int'(oFrame_Err),  0);

        // 1: single press
        exp_q.push_back(8'd0);
        send(8'h1C);
        checkpoint("press_a", 0);

        // 2: typematic repeat then release
        send(8'h1C);
        checkpoint("repeat_a", 0);
        exp_q.push_back(8'd99);
        send(8'hF0); send(8'h1C);
        checkpoint("release_a", 99);

        // 3: last pressed wins; releasing the older key does nothing
        exp_q.push_back(8'd0);
        send(8'h1C);
        exp_q.push_back(8'd2);
        send(8'h23);
        send(8'hF0); send(8'h1C);
        checkpoint("overlap", 2);
        exp_q.push_back(8'd99);
        send(8'hF0); send(8'h23);
        checkpoint("release_d", 99);

        // 4: parity error, stop error, bad start bit
        exp_err++;
        send_frame(8'h1B, 1'b1, 1'b1);
        checkpoint("parity_err", 99);
        exp_err++;
        send_frame(8'h1C, 1'b0, 1'b0);
        checkpoint("stop_err", 99);
        exp_err++;
        ps2_bit(1'b1);
        repeat (40) @(negedge iClk);
        checkpoint("start_err", 99);

        // 5: partial frame times out, then a clean frame is accepted
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        repeat (TMO + 60) @(negedge iClk);
        exp_err++;
        checkpoint("timeout", 99);
        exp_q.push_back(8'd3);
        send(8'h2B);
        checkpoint("after_tmo", 3);
        exp_q.push_back(8'd99);
        send(8'hF0); send(8'h2B);
        checkpoint("release_f", 99);

        // 6: extended code ignored; sharp key depends on build
        send(8'hE0); send(8'h1C);
        checkpoint("extended", 99);
`ifdef PS2_SHARPS_EN
        exp_q.push_back(8'd8);
        send(8'h1D);
        checkpoint("sharp_w", 8);
        exp_q.push_back(8'd99);
        send(8'hF0); send(8'h1D);
        checkpoint("sharp_rel", 99);
`else
        send(8'h1D);
        checkpoint("sharp_w", 99);
        send(8'hF0); send(8'h1D);
        checkpoint("sharp_rel", 99);
`endif
        // Prefix state must not leak: a plain press after E0-sequence works
        exp_q.push_back(8'd7);
        send(8'h42);
        checkpoint("press_k", 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
